// File: rtl/laplacian.sv
// Streaming 3x3 4-neighbour Laplacian edge filter for 8-bit grayscale video, one pixel per clock.
// Fixed 4-clock latency for data and syncs; no back-pressure, blanking between lines/frames is arbitrary.
module laplacian #(
  parameter int IMG_WIDTH = 1280,
  parameter int LATENCY   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pre_img_vsync,
  input  logic       pre_img_hsync,
  input  logic       pre_img_valid,
  input  logic [7:0] pre_img_data,
  output logic       post_img_vsync,
  output logic       post_img_hsync,
  output logic       post_img_valid,
  output logic [7:0] post_img_data
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  logic [CW-1:0]      col;
  logic [1:0]         row;
  logic               valid_q;
  logic [7:0]         lb1 [IMG_WIDTH];
  logic [7:0]         lb2 [IMG_WIDTH];
  logic [7:0]         top_tap;
  logic [7:0]         mid_tap;
  logic [7:0]         t1, t2, m0, m1, m2, b1, b2;
  logic [9:0]         nsum;
  logic [9:0]         c4;
  logic signed [10:0] lap;
  logic [10:0]        mag;
  logic [2:0]         sync_pipe [LATENCY];

  // Row counter only needs to tell rows 0, 1 and >=2 apart, so it saturates.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      col     <= '0;
      row     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pre_img_valid;
      if (pre_img_valid)
        col <= (col == CW'(IMG_WIDTH - 1)) ? '0 : col + 1'b1;
      else
        col <= '0;
      if (pre_img_vsync)
        row <= '0;
      else if (valid_q && !pre_img_valid && row != 2'd3)
        row <= row + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (pre_img_valid) begin
      lb1[col] <= pre_img_data;
      lb2[col] <= lb1[col];
    end
  end

  // Stale buffer contents above the top of the frame are masked rather than cleared.
  assign top_tap = (row >= 2'd2) ? lb2[col] : 8'd0;
  assign mid_tap = (row != 2'd0) ? lb1[col] : 8'd0;

  // Stage 1: window capture; corners are never used so they are not stored.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      {t1, t2, m0, m1, m2, b1, b2} <= '0;
    end else if (pre_img_valid) begin
      t1 <= t2;  t2 <= top_tap;
      m0 <= m1;  m1 <= m2;  m2 <= mid_tap;
      b1 <= b2;  b2 <= pre_img_data;
    end else begin
      {t1, t2, m0, m1, m2, b1, b2} <= '0;
    end
  end

  always_comb begin
    mag = lap[10] ? 11'(-lap) : 11'(lap);
  end

  // Stages 2-4: neighbour sum / 4*centre, subtraction, magnitude with saturation.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      nsum          <= '0;
      c4            <= '0;
      lap           <= '0;
      post_img_data <= '0;
    end else begin
      nsum          <= {2'b00, t1} + {2'b00, b1} + {2'b00, m0} + {2'b00, m2};
      c4            <= {m1, 2'b00};
      lap           <= $signed({1'b0, c4}) - $signed({1'b0, nsum});
      post_img_data <= sync_pipe[LATENCY-2][0] ?
                       ((mag > 11'd255) ? 8'd255 : mag[7:0]) : 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < LATENCY; i++) sync_pipe[i] <= '0;
    end else begin
      sync_pipe[0] <= {pre_img_vsync, pre_img_hsync, pre_img_valid};
      for (int i = 1; i < LATENCY; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign {post_img_vsync, post_img_hsync, post_img_valid} = sync_pipe[LATENCY-1];

endmodule

// File: tb/tb_laplacian.sv
// Directed-frame bench for laplacian on a reduced 16x8 image with a per-cycle output checker.
module tb_laplacian;

  localparam int W = 16;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pre_img_vsync = 1'b0;
  logic       pre_img_hsync = 1'b0;
  logic       pre_img_valid = 1'b0;
  logic [7:0] pre_img_data  = 8'd0;
  logic       post_img_vsync;
  logic       post_img_hsync;
  logic       post_img_valid;
  logic [7:0] post_img_data;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         img     [H][W];
  logic [7:0] got     [H][W];
  logic [7:0] ref_img [H][W];
  int         exp_q[$];
  bit         check_data = 1'b1;
  logic [2:0] hist [8];
  int         edge_cnt = 0;
  int         out_idx  = 0;

  laplacian #(.IMG_WIDTH(W), .LATENCY(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pre_img_vsync  (pre_img_vsync),
    .pre_img_hsync  (pre_img_hsync),
    .pre_img_valid  (pre_img_valid),
    .pre_img_data   (pre_img_data),
    .post_img_vsync (post_img_vsync),
    .post_img_hsync (post_img_hsync),
    .post_img_valid (post_img_valid),
    .post_img_data  (post_img_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: window centred on input (r-1,c-1), zero outside the top/left of the frame.
  function automatic int px(int r, int c);
    if (r < 0 || c < 0) return 0;
    return img[r][c];
  endfunction

  function automatic int exp_pix(int r, int c);
    int l;
    l = 4 * px(r-1, c-1) - (px(r-2, c-1) + px(r, c-1) + px(r-1, c-2) + px(r-1, c));
    if (l < 0) l = -l;
    return (l > 255) ? 255 : l;
  endfunction

  always @(posedge clk) begin
    hist[edge_cnt % 8] = rst_n ? 3'b000 : {pre_img_vsync, pre_img_hsync, pre_img_valid};
    edge_cnt++;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("reset_outputs", {20'd0, post_img_vsync, post_img_hsync, post_img_valid, 1'b0, post_img_data}, 32'd0);
    end else if (edge_cnt >= 4) begin
      chk("sync_delay", {29'd0, post_img_vsync, post_img_hsync, post_img_valid},
          {29'd0, hist[(edge_cnt - 4) % 8]});
      if (post_img_vsync) out_idx = 0;
      if (post_img_valid) begin
        if (check_data) begin
          if (exp_q.size() == 0) chk("data_unexpected", 1, 0);
          else chk("data", {24'd0, post_img_data}, exp_q.pop_front());
        end
        if (out_idx < W*H) got[out_idx / W][out_idx % W] = post_img_data;
        out_idx++;
      end else begin
        chk("data_idle_zero", {24'd0, post_img_data}, 0);
      end
    end
  end

  task automatic drive(bit vs, bit hs, bit vld, int d);
    pre_img_vsync = vs;
    pre_img_hsync = hs;
    pre_img_valid = vld;
    pre_img_data  = 8'(d);
    @(posedge clk); #1;
  endtask

  task automatic mid_reset();
    pre_img_vsync = 1'b0; pre_img_hsync = 1'b0; pre_img_valid = 1'b0; pre_img_data = 8'd0;
    rst_n = 1'b1;
    #1;
    chk("midrst_vsync", {31'd0, post_img_vsync}, 0);
    chk("midrst_hsync", {31'd0, post_img_hsync}, 0);
    chk("midrst_valid", {31'd0, post_img_valid}, 0);
    chk("midrst_data",  {24'd0, post_img_data}, 0);
    exp_q.delete();
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
  endtask

  task automatic send_frame(int rst_row);
    repeat (3) drive(1, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0);
    for (int r = 0; r < H; r++) begin
      repeat (2) drive(0, 1, 0, 0);
      repeat (2) drive(0, 0, 0, 0);
      for (int c = 0; c < W; c++) begin
        if (r == rst_row && c == W/2) begin
          mid_reset();
          return;
        end
        exp_q.push_back(exp_pix(r, c));
        drive(0, 0, 1, img[r][c]);
      end
      repeat (2) drive(0, 0, 0, 0);
    end
    repeat (8) drive(0, 0, 0, 0);
    chk("frame_valid_count", out_idx, W*H);
    chk("frame_queue_drained", exp_q.size(), 0);
  endtask

  task automatic fill(int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r][c] = 100;
          1:       img[r][c] = (r == 3 && c == 3) ? 255 : 0;
          default: img[r][c] = (c < W/2) ? 0 : 40;
        endcase
  endtask

  task automatic lit(string nm, int r, int c, int v);
    chk({nm, "_model"}, exp_pix(r, c), v);
    chk({nm, "_dut"}, {24'd0, got[r][c]}, v);
  endtask

  task automatic pulse_test(string nm, int sel, int width);
    logic [7:0] seen;
    logic [7:0] want;
    check_data = 1'b0;
    seen = '0;
    want = 8'(((1 << width) - 1) << 4);
    fork
      begin
        for (int i = 0; i < width; i++)
          drive(sel == 2, sel == 1, sel == 0, 77);
        pre_img_vsync = 1'b0; pre_img_hsync = 1'b0; pre_img_valid = 1'b0; pre_img_data = 8'd0;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          seen[i] = (sel == 0) ? post_img_valid : (sel == 1) ? post_img_hsync : post_img_vsync;
        end
      end
    join
    @(posedge clk); #1;
    chk(nm, {24'd0, seen}, {24'd0, want});
    check_data = 1'b1;
  endtask

  task automatic compare_ref(string nm);
    int diff;
    diff = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (got[r][c] !== ref_img[r][c]) diff++;
    chk(nm, diff, 0);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    chk("reset_post_valid", {31'd0, post_img_valid}, 0);
    chk("reset_post_data", {24'd0, post_img_data}, 0);
    chk("reset_post_syncs", {30'd0, post_img_vsync, post_img_hsync}, 0);
    rst_n = 1'b0;
    repeat (2) drive(0, 0, 0, 0);

    fill(0);
    send_frame(-1);
    lit("flat_r0c5", 0, 5, 100);
    lit("flat_r1c5", 1, 5, 100);
    lit("flat_r2c0", 2, 0, 100);
    lit("flat_r2c1", 2, 1, 100);
    lit("flat_r5c7", 5, 7, 0);
    lit("flat_r7c15", 7, 15, 0);
    ref_img = got;

    fill(1);
    send_frame(-1);
    lit("imp_centre", 4, 4, 255);
    lit("imp_up", 3, 4, 255);
    lit("imp_down", 5, 4, 255);
    lit("imp_left", 4, 3, 255);
    lit("imp_right", 4, 5, 255);
    lit("imp_diag", 5, 5, 0);
    lit("imp_other", 3, 3, 0);

    fill(2);
    send_frame(-1);
    lit("step_c8", 3, 8, 40);
    lit("step_c9", 3, 9, 40);
    lit("step_c12", 3, 12, 0);
    lit("step_c4", 3, 4, 0);

    pulse_test("lat_valid", 0, 1);
    pulse_test("lat_hsync", 1, 3);
    pulse_test("lat_vsync", 2, 2);

    fill(0);
    send_frame(4);
    repeat (3) drive(0, 0, 0, 0);
    send_frame(-1);
    compare_ref("flat_after_reset");
    send_frame(-1);
    compare_ref("flat_back_to_back");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/laplacian.md
# laplacian

Streaming 3×3 Laplacian edge-detection filter for 8-bit grayscale video, 1280 pixels per active line. It sits in the video pipeline between a raster source and a downstream sink, for example a frame writer. Each accepted pixel produces exactly one output pixel after a fixed pipeline delay. Frame and line sync are forwarded with the same delay.

## Interface
- `IMG_WIDTH`, default 1280: active pixels per line; sets the depth of each line buffer.
- `LATENCY`, default 4: pipeline depth in clocks. It is fixed by the architecture below and is not meant to be changed.

Ports:
- `clk`, in, 1: single clock domain.
- `rst_n`, in, 1: reset. Asynchronous assertion and active-high (asserted = 1); the port name is kept for integration compatibility.
- `pre_img_vsync`, in, 1: frame sync, high during the vertical sync interval.
- `pre_img_hsync`, in, 1: line sync.
- `pre_img_valid`, in, 1: input pixel qualifier, high for each active pixel.
- `pre_img_data`, in, 8: input grayscale pixel.
- `post_img_vsync`, out, 1: `pre_img_vsync` delayed by `LATENCY` clocks.
- `post_img_hsync`, out, 1: `pre_img_hsync` delayed by `LATENCY` clocks.
- `post_img_valid`, out, 1: `pre_img_valid` delayed by `LATENCY` clocks.
- `post_img_data`, out, 8: filtered pixel; 0 whenever `post_img_valid` is 0.

## Operation
- **Column counter.**
  - Increments on each valid pixel.
  - Clears when `pre_img_valid` is 0, so each active run starts at column 0.
- **Row counter.**
  - Increments on each falling edge of `pre_img_valid`.
  - Clears while `pre_img_vsync` is 1; saturates at 3, since only rows 0, 1 and ≥2 need to be distinguished.
- **Line buffers.**
  - Two `IMG_WIDTH`×8 buffers, indexed by the column counter, hold the previous two rows.
  - Each is read and written on every valid pixel.
- **Window.** At input pixel (r, c) the 3×3 window covers input rows r-2..r and columns c-2..c. Its center is input pixel (r-1, c-1), so the output image is offset by one row and one column down-right.
- **Zero padding.**
  - Rows above row 0: line-buffer taps read as 0 when the row counter is 0 (both upper rows) or 1 (the top row only).
  - Columns left of column 0: the horizontal shift registers clear when valid is low.
  - No padding is applied on the right or bottom edges.
- **Kernel.** 4-neighbour Laplacian [0 1 0; 1 -4 1; 0 1 0]:
  - L = 4·C − (U + D + Lf + Rt), computed as signed 11-bit.
  - `post_img_data` = min(|L|, 255).
- **Pipeline.**
  - Stage 1: window capture.
  - Stage 2: neighbour sum (10-bit) and 4·C.
  - Stage 3: subtraction.
  - Stage 4: absolute value and saturation, output register.
- **Sync.** The three sync/valid signals pass through a 4-deep shift register and are never modified.
- **Throughput.** One pixel per clock with no back-pressure. Blanking between lines and frames is arbitrary.

## Timing
- **Reset state.** All outputs, the counters, the window and pipeline registers are 0. Line-buffer contents are not cleared; they are masked by the row counter.
- **Latency.** Input valid at clock edge k appears as `post_img_valid` at edge k+4, with the matching data.
- **Counts.** The number of output-valid pixels per line and lines per frame equals the input counts; for 1280×720 that is 921600 per frame.
- **Reset mid-frame.** Outputs are 0 immediately. Output is not guaranteed correct until the next `pre_img_vsync` pulse restarts the row counter.
- **Partial lines.** A valid run shorter than `IMG_WIDTH` is legal; the unwritten buffer entries hold stale data.

## Test plan
- **Flat frame.** All pixels = 100, 1280×720, source H total 1650, V total 750.
  - Output row 0: 100 at every column.
  - Output row 1: 100.
  - Rows ≥2: 0, except output column 0 = 100 and column 1 = 100.
  - Exactly 1280×720 valid outputs.
- **Impulse.** Zero frame with 255 at input (10,10).
  - Output (11,11) = 255 (1020 saturated).
  - Outputs (10,11), (12,11), (11,10), (11,12) = 255.
  - Diagonals and all other pixels = 0.
- **Vertical step.** Columns <640 = 0, ≥640 = 40.
  - On rows ≥2, output columns 640 and 641 = 40.
  - Other interior columns = 0.
- **Latency and sync.** Single-cycle valid and hsync/vsync pulses at known edges appear exactly 4 clocks later on the `post_` outputs, with widths unchanged.
- **Mid-frame reset.** Assert `rst_n` at row 300.
  - All outputs are 0 within the same cycle.
  - After release and a new vsync, the flat-frame results repeat exactly.
- **Back-to-back frames.** The second frame's output is bit-identical to the first, confirming the row counter restarts on vsync.
